// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths, FSM states and requester indices for the register-file
// write-port sequencer.
package reg_write_arbiter_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam int PORT_ALU  = 0;
  localparam int PORT_LOAD = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/reg_write_arbiter_rr_arb2.sv
// Two-way round-robin grant. The last_grant flop advances only when a grant
// is issued, and a grant is issued only to a valid requester.
module reg_write_arbiter_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[1]) begin
      last_d = 1'b1;
    end else if (gnt_o[0]) begin
      last_d = 1'b0;
    end
  end

  // Reset to "port 1 went last" so port 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port sequencer: zero-fills every register after reset,
// then round-robins the single write port between the ALU and load paths.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VALID0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] DATA0,
  output logic              READY0,
  input  logic              VALID1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              READY1,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN,
  output logic              INIT_DONE
);

  // One extra counter bit keeps the terminal count from aliasing to zero.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] CLR_STEP = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              init_done_q, init_done_d;
  logic [1:0]        gnt;

  reg_write_arbiter_rr_arb2 u_rr_arb2 (
    .clk_i (CLK),
    .rst_i (RESET),
    .en_i  (state_q == RUN),
    .req_i ({VALID1, VALID0}),
    .gnt_o (gnt)
  );

  assign READY0 = gnt[PORT_ALU];
  assign READY1 = gnt[PORT_LOAD];

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    write_d     = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    init_done_d = init_done_q;
    unique case (state_q)
      CLEAR: begin
        write_d   = 1'b1;
        waddr_d   = clr_cnt_q[ADDR_W-1:0];
        wdata_d   = '0;
        clr_cnt_d = clr_cnt_q + CLR_STEP;
        if (clr_cnt_q == CLR_LAST) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        if (gnt[PORT_ALU]) begin
          write_d = 1'b1;
          waddr_d = ADDR0;
          wdata_d = DATA0;
        end else if (gnt[PORT_LOAD]) begin
          write_d = 1'b1;
          waddr_d = ADDR1;
          wdata_d = DATA1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      write_q     <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      write_q     <= write_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign WRITE     = write_q;
  assign INADDRESS = waddr_q;
  assign IN        = wdata_q;
  assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural 8x8 register file
// hanging off the write port.
module tb_reg_write_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       VALID0, VALID1;
  logic [2:0] ADDR0, ADDR1;
  logic [7:0] DATA0, DATA1;
  logic       READY0, READY1;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic       INIT_DONE;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rf [8];

  reg_write_arbiter dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .VALID0    (VALID0),
    .ADDR0     (ADDR0),
    .DATA0     (DATA0),
    .READY0    (READY0),
    .VALID1    (VALID1),
    .ADDR1     (ADDR1),
    .DATA1     (DATA1),
    .READY1    (READY1),
    .WRITE     (WRITE),
    .INADDRESS (INADDRESS),
    .IN        (IN),
    .INIT_DONE (INIT_DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (WRITE) rf[INADDRESS] <= IN;
  end

  task automatic test_reset();
    for (int r = 0; r < 8; r++) rf[r] = 8'hFF;
    RESET = 1'b1;
    VALID0 = 1'b0; ADDR0 = 3'd0; DATA0 = 8'd0;
    VALID1 = 1'b0; ADDR1 = 3'd0; DATA1 = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if ({WRITE, INADDRESS, IN} !== 12'h000) begin failures++; $display("FAIL reset_outputs got=%h exp=000", {WRITE, INADDRESS, IN}); end
    checks++; if (INIT_DONE !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", INIT_DONE); end
    checks++; if ({READY0, READY1} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {READY0, READY1}); end
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      checks++; if ({WRITE, INADDRESS, IN} !== {1'b1, 3'(i), 8'h00}) begin failures++; $display("FAIL fill_write[%0d] got=%h exp=%h", i, {WRITE, INADDRESS, IN}, {1'b1, 3'(i), 8'h00}); end
      checks++; if (INIT_DONE !== (i == 7)) begin failures++; $display("FAIL fill_init_done[%0d] got=%b exp=%b", i, INIT_DONE, (i == 7)); end
    end
    @(posedge CLK); #1;
    checks++; if ({WRITE, INIT_DONE} !== 2'b01) begin failures++; $display("FAIL fill_idle got=%b exp=01", {WRITE, INIT_DONE}); end
    for (int r = 0; r < 8; r++) begin
      checks++; if (rf[r] !== 8'h00) begin failures++; $display("FAIL fill_rf[%0d] got=%h exp=00", r, rf[r]); end
    end
  endtask

  task automatic test_single();
    VALID0 = 1'b1; ADDR0 = 3'd2; DATA0 = 8'd95;
    #1;
    checks++; if ({READY0, READY1} !== 2'b10) begin failures++; $display("FAIL single0_ready got=%b exp=10", {READY0, READY1}); end
    @(posedge CLK); #1;
    VALID0 = 1'b0;
    checks++; if ({WRITE, INADDRESS, IN} !== {1'b1, 3'd2, 8'd95}) begin failures++; $display("FAIL single0_write got=%h exp=%h", {WRITE, INADDRESS, IN}, {1'b1, 3'd2, 8'd95}); end
    @(posedge CLK); #1;
    checks++; if ({WRITE, INADDRESS, IN} !== {1'b0, 3'd2, 8'd95}) begin failures++; $display("FAIL single0_hold got=%h exp=%h", {WRITE, INADDRESS, IN}, {1'b0, 3'd2, 8'd95}); end
    checks++; if (rf[2] !== 8'd95) begin failures++; $display("FAIL single0_rf got=%0d exp=95", rf[2]); end
    VALID1 = 1'b1; ADDR1 = 3'd5; DATA1 = 8'hA5;
    #1;
    checks++; if ({READY0, READY1} !== 2'b01) begin failures++; $display("FAIL single1_ready got=%b exp=01", {READY0, READY1}); end
    @(posedge CLK); #1;
    VALID1 = 1'b0;
    checks++; if ({WRITE, INADDRESS, IN} !== {1'b1, 3'd5, 8'hA5}) begin failures++; $display("FAIL single1_write got=%h exp=%h", {WRITE, INADDRESS, IN}, {1'b1, 3'd5, 8'hA5}); end
    @(posedge CLK); #1;
    checks++; if (WRITE !== 1'b0) begin failures++; $display("FAIL single1_idle got=%b exp=0", WRITE); end
  endtask

  task automatic test_contention();
    logic [11:0] exp_w;
    VALID0 = 1'b1; ADDR0 = 3'd1; DATA0 = 8'd28;
    VALID1 = 1'b1; ADDR1 = 3'd4; DATA1 = 8'd6;
    for (int k = 0; k < 4; k++) begin
      exp_w = (k % 2 == 0) ? {1'b1, 3'd1, 8'd28} : {1'b1, 3'd4, 8'd6};
      #1;
      checks++; if ({READY0, READY1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL contend_ready[%0d] got=%b exp=%b", k, {READY0, READY1}, ((k % 2 == 0) ? 2'b10 : 2'b01)); end
      @(posedge CLK); #1;
      checks++; if ({WRITE, INADDRESS, IN} !== exp_w) begin failures++; $display("FAIL contend_write[%0d] got=%h exp=%h", k, {WRITE, INADDRESS, IN}, exp_w); end
    end
    VALID0 = 1'b0; VALID1 = 1'b0;
    @(posedge CLK); #1;
    checks++; if (WRITE !== 1'b0) begin failures++; $display("FAIL contend_idle got=%b exp=0", WRITE); end
  endtask

  task automatic test_collision();
    logic [11:0] exp_w;
    VALID0 = 1'b1; ADDR0 = 3'd7; DATA0 = 8'd50;
    VALID1 = 1'b1; ADDR1 = 3'd7; DATA1 = 8'd15;
    for (int k = 0; k < 2; k++) begin
      exp_w = (k == 0) ? {1'b1, 3'd7, 8'd50} : {1'b1, 3'd7, 8'd15};
      #1;
      checks++; if ({READY0, READY1} !== ((k == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL collide_ready[%0d] got=%b exp=%b", k, {READY0, READY1}, ((k == 0) ? 2'b10 : 2'b01)); end
      @(posedge CLK); #1;
      if (k == 0) VALID0 = 1'b0;
      checks++; if ({WRITE, INADDRESS, IN} !== exp_w) begin failures++; $display("FAIL collide_write[%0d] got=%h exp=%h", k, {WRITE, INADDRESS, IN}, exp_w); end
    end
    VALID1 = 1'b0;
    @(posedge CLK); #1;
    checks++; if (rf[7] !== 8'd15) begin failures++; $display("FAIL collide_rf7 got=%0d exp=15", rf[7]); end
    checks++; if ({rf[1], rf[4]} !== {8'd28, 8'd6}) begin failures++; $display("FAIL contend_rf got=%h exp=%h", {rf[1], rf[4]}, {8'd28, 8'd6}); end
  endtask

  task automatic test_reset_mid();
    VALID0 = 1'b1; ADDR0 = 3'd3; DATA0 = 8'h77;
    #1;
    checks++; if (READY0 !== 1'b1) begin failures++; $display("FAIL mid_ready_pre got=%b exp=1", READY0); end
    @(posedge CLK); #1;
    ADDR0 = 3'd6; DATA0 = 8'h3C;
    checks++; if ({WRITE, INADDRESS, IN} !== {1'b1, 3'd3, 8'h77}) begin failures++; $display("FAIL mid_write_pre got=%h exp=%h", {WRITE, INADDRESS, IN}, {1'b1, 3'd3, 8'h77}); end
    #2;
    RESET = 1'b1;
    #1;
    checks++; if ({WRITE, INADDRESS, IN} !== 12'h000) begin failures++; $display("FAIL mid_async_outputs got=%h exp=000", {WRITE, INADDRESS, IN}); end
    checks++; if ({INIT_DONE, READY0} !== 2'b00) begin failures++; $display("FAIL mid_async_status got=%b exp=00", {INIT_DONE, READY0}); end
    VALID0 = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      checks++; if ({WRITE, INADDRESS, IN, INIT_DONE} !== {1'b1, 3'(i), 8'h00, (i == 7)}) begin failures++; $display("FAIL mid_refill[%0d] got=%h exp=%h", i, {WRITE, INADDRESS, IN, INIT_DONE}, {1'b1, 3'(i), 8'h00, (i == 7)}); end
    end
    VALID0 = 1'b1; ADDR0 = 3'd0; DATA0 = 8'h01;
    VALID1 = 1'b1; ADDR1 = 3'd1; DATA1 = 8'h02;
    #1;
    checks++; if ({READY0, READY1} !== 2'b10) begin failures++; $display("FAIL first_tie_ready got=%b exp=10", {READY0, READY1}); end
    @(posedge CLK); #1;
    VALID0 = 1'b0;
    checks++; if ({WRITE, INADDRESS, IN} !== {1'b1, 3'd0, 8'h01}) begin failures++; $display("FAIL first_tie_write got=%h exp=%h", {WRITE, INADDRESS, IN}, {1'b1, 3'd0, 8'h01}); end
    #1;
    checks++; if ({READY0, READY1} !== 2'b01) begin failures++; $display("FAIL second_ready got=%b exp=01", {READY0, READY1}); end
    @(posedge CLK); #1;
    VALID1 = 1'b0;
    checks++; if ({WRITE, INADDRESS, IN} !== {1'b1, 3'd1, 8'h02}) begin failures++; $display("FAIL second_write got=%h exp=%h", {WRITE, INADDRESS, IN}, {1'b1, 3'd1, 8'h02}); end
    @(posedge CLK); #1;
    checks++; if ({rf[0], rf[1], rf[3], rf[6]} !== 32'h01020000) begin failures++; $display("FAIL mid_rf got=%h exp=01020000", {rf[0], rf[1], rf[3], rf[6]}); end
  endtask

  task automatic test_requests_during_clear();
    RESET = 1'b1;
    VALID1 = 1'b1; ADDR1 = 3'd2; DATA1 = 8'h5A;
    #1;
    checks++; if (READY1 !== 1'b0) begin failures++; $display("FAIL clear_ready_rst got=%b exp=0", READY1); end
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (READY1 !== 1'b0) begin failures++; $display("FAIL clear_ready[%0d] got=%b exp=0", i, READY1); end
      @(posedge CLK); #1;
      checks++; if ({WRITE, INADDRESS, IN} !== {1'b1, 3'(i), 8'h00}) begin failures++; $display("FAIL clear_fill[%0d] got=%h exp=%h", i, {WRITE, INADDRESS, IN}, {1'b1, 3'(i), 8'h00}); end
    end
    checks++; if ({INIT_DONE, READY1} !== 2'b11) begin failures++; $display("FAIL clear_done_ready got=%b exp=11", {INIT_DONE, READY1}); end
    @(posedge CLK); #1;
    VALID1 = 1'b0;
    checks++; if ({WRITE, INADDRESS, IN} !== {1'b1, 3'd2, 8'h5A}) begin failures++; $display("FAIL clear_accept got=%h exp=%h", {WRITE, INADDRESS, IN}, {1'b1, 3'd2, 8'h5A}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_collision();
    test_reset_mid();
    test_requests_during_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
